sifh_frame_sequencer: RTL and testbench

//  Frame-level controller for the serial SiFH histogram datapath. Accepts the TDC timestamp stream,

---
 rtl/sifh_frame_sequencer_pkg.sv | 37 +++
 rtl/sifh_idx_counter.sv | 54 +++++
 rtl/sifh_frame_sequencer.sv | 150 +++++++++++++++
 tb/tb_sifh_frame_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sifh_frame_sequencer_pkg.sv
// Shared constants and types for the SiFH frame sequencer.
//   DFLT_*     : default frame geometry and timing
//   NO_PHOTON  : all-ones timestamp sentinel, forwarded unchanged by the sequencer
//   state_e    : sequencer FSM states
//   wrap_t     : per-stage wrap flags of the index counter
//   idx_w()    : index width for a count of n items (never below 1 bit)
package sifh_frame_sequencer_pkg;

  localparam int unsigned DFLT_NP        = 10;
  localparam int unsigned DFLT_DATA_NUM  = 2;
  localparam int unsigned DFLT_PIXEL_NUM = 200;
  localparam int unsigned DFLT_ACQ_NUM   = 33333;
  localparam int unsigned DFLT_PIPE_LAT  = 3;
  localparam int unsigned DFLT_CLR_CYC   = 2;

  localparam logic [DFLT_NP-1:0] NO_PHOTON = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COARSE  = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_FINE    = 3'd4,
    ST_CAPTURE = 3'd5
  } state_e;

  typedef struct packed {
    logic acq;
    logic pix;
    logic inp;
  } wrap_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sifh_idx_counter.sv
// Cascaded input/pixel/acquisition counter; advances on accept only.
//   clk, res     : clock, async active-low reset
//   accept       : beat accepted this cycle
//   pixel_idx    : pixel of the next accepted beat
//   acq_idx      : acquisition of the next accepted beat
//   wrap_c       : each stage currently at its maximum
//   last_beat_c  : accept with all stages at maximum (final beat of a pass)
module sifh_idx_counter
  import sifh_frame_sequencer_pkg::*;
#(
  parameter int unsigned DATA_NUM  = DFLT_DATA_NUM,
  parameter int unsigned PIXEL_NUM = DFLT_PIXEL_NUM,
  parameter int unsigned ACQ_NUM   = DFLT_ACQ_NUM,
  parameter int unsigned IN_W      = idx_w(DATA_NUM),
  parameter int unsigned PIX_W     = idx_w(PIXEL_NUM),
  parameter int unsigned ACQ_W     = idx_w(ACQ_NUM)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             accept,
  output logic [PIX_W-1:0] pixel_idx,
  output logic [ACQ_W-1:0] acq_idx,
  output wrap_t            wrap_c,
  output logic             last_beat_c
);

  logic [IN_W-1:0] in_idx;

  // Stage-at-max flags
  always_comb begin
    wrap_c.inp  = (in_idx    == IN_W'(DATA_NUM - 1));
    wrap_c.pix  = (pixel_idx == PIX_W'(PIXEL_NUM - 1));
    wrap_c.acq  = (acq_idx   == ACQ_W'(ACQ_NUM - 1));
    last_beat_c = accept && wrap_c.inp && wrap_c.pix && wrap_c.acq;
  end

  // Ripple carry from input count into pixel, then acquisition
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      in_idx    <= '0;
      pixel_idx <= '0;
      acq_idx   <= '0;
    end else if (accept) begin
      in_idx <= wrap_c.inp ? '0 : in_idx + IN_W'(1);
      if (wrap_c.inp) begin
        pixel_idx <= wrap_c.pix ? '0 : pixel_idx + PIX_W'(1);
        if (wrap_c.pix) begin
          acq_idx <= wrap_c.acq ? '0 : acq_idx + ACQ_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sifh_frame_sequencer.sv
// Frame-level controller for the serial SiFH histogram datapath: gates TDC beats into the
// histogram builder, runs coarse then fine pass with a flush+clear between and after them,
// and latches the builder peak vector at frame end.
// Build option: SIFH_AUTO_RESTART_EN -- when defined, a finished frame restarts the coarse
// pass immediately instead of returning to IDLE.
//   clk, res          : clock, async active-low reset
//   start             : frame request, honoured in IDLE only
//   in_valid/in_data  : upstream timestamp stream (all-ones = no photon, passed through)
//   in_ready          : beat accepted when in_valid is also high
//   hb_wr_en/hb_data  : builder write strobe and timestamp (one cycle after accept)
//   hb_pass           : 0 coarse, 1 fine
//   hb_clr_n          : builder clear, active low
//   hb_result         : builder peak vector
//   frame_result      : peak vector of the last completed frame
//   frame_done        : one-cycle pulse when frame_result updates
//   busy              : sequencer not in IDLE
//   pixel_idx/acq_idx : position of the next accepted beat
module sifh_frame_sequencer
  import sifh_frame_sequencer_pkg::*;
#(
  parameter int unsigned NP        = DFLT_NP,
  parameter int unsigned DATA_NUM  = DFLT_DATA_NUM,
  parameter int unsigned PIXEL_NUM = DFLT_PIXEL_NUM,
  parameter int unsigned ACQ_NUM   = DFLT_ACQ_NUM,
  parameter int unsigned PIPE_LAT  = DFLT_PIPE_LAT,
  parameter int unsigned CLR_CYC   = DFLT_CLR_CYC,
  parameter int unsigned PIX_W     = idx_w(PIXEL_NUM),
  parameter int unsigned ACQ_W     = idx_w(ACQ_NUM)
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [NP-1:0]           in_data,
  output logic                    in_ready,
  output logic                    hb_wr_en,
  output logic [NP-1:0]           hb_data,
  output logic                    hb_pass,
  output logic                    hb_clr_n,
  input  logic [NP*PIXEL_NUM-1:0] hb_result,
  output logic [NP*PIXEL_NUM-1:0] frame_result,
  output logic                    frame_done,
  output logic                    busy,
  output logic [PIX_W-1:0]        pixel_idx,
  output logic [ACQ_W-1:0]        acq_idx
);

  localparam int unsigned WAIT_MAX = (PIPE_LAT > CLR_CYC) ? PIPE_LAT : CLR_CYC;
  localparam int unsigned WAIT_W   = idx_w(WAIT_MAX);

  state_e            state;
  state_e            state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nx;
  logic              pass_nx;
  logic              accept_c;
  logic              last_beat_c;
  wrap_t             wrap_c;
  logic              unused_wrap;

  // in_ready is a flop of the decoded next state, so it equals a decode of the state register
  assign accept_c    = in_valid && in_ready;
  // Wrap flags are only needed as a debug tap at this level
  assign unused_wrap = ^wrap_c;

  sifh_idx_counter #(
    .DATA_NUM  (DATA_NUM),
    .PIXEL_NUM (PIXEL_NUM),
    .ACQ_NUM   (ACQ_NUM),
    .PIX_W     (PIX_W),
    .ACQ_W     (ACQ_W)
  ) u_idx (
    .clk         (clk),
    .res         (res),
    .accept      (accept_c),
    .pixel_idx   (pixel_idx),
    .acq_idx     (acq_idx),
    .wrap_c      (wrap_c),
    .last_beat_c (last_beat_c)
  );

  // Next-state, wait-counter and pass-flag decode
  always_comb begin
    state_nx = state;
    wait_nx  = '0;
    pass_nx  = hb_pass;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_COARSE;
      end
      ST_COARSE, ST_FINE: begin
        if (last_beat_c) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (wait_cnt == WAIT_W'(PIPE_LAT - 1)) state_nx = ST_CLEAR;
        else                                   wait_nx  = wait_cnt + WAIT_W'(1);
      end
      ST_CLEAR: begin
        if (wait_cnt == WAIT_W'(CLR_CYC - 1)) begin
          // hb_pass tells which pass just drained
          if (hb_pass) begin
            state_nx = ST_CAPTURE;
          end else begin
            state_nx = ST_FINE;
            pass_nx  = 1'b1;
          end
        end else begin
          wait_nx = wait_cnt + WAIT_W'(1);
        end
      end
      ST_CAPTURE: begin
        pass_nx = 1'b0;
`ifdef SIFH_AUTO_RESTART_EN
        state_nx = ST_COARSE;
`else
        state_nx = ST_IDLE;
`endif
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      in_ready     <= 1'b0;
      hb_wr_en     <= 1'b0;
      hb_data      <= '0;
      hb_pass      <= 1'b0;
      hb_clr_n     <= 1'b1;
      frame_result <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      in_ready <= (state_nx == ST_COARSE) || (state_nx == ST_FINE);
      hb_wr_en <= accept_c;
      if (accept_c) hb_data <= in_data;
      hb_pass  <= pass_nx;
      hb_clr_n <= (state_nx != ST_CLEAR);
      if (state == ST_CAPTURE) frame_result <= hb_result;
      frame_done <= (state == ST_CAPTURE);
      busy       <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sifh_frame_sequencer.sv
// Self-checking bench for sifh_frame_sequencer (small geometry: 12 beats per pass).
module tb_sifh_frame_sequencer;

  localparam int unsigned NP    = 10;
  localparam int unsigned DN    = 2;
  localparam int unsigned PN    = 2;
  localparam int unsigned AN    = 3;
  localparam int unsigned PL    = 3;
  localparam int unsigned CC    = 2;
  localparam int unsigned B     = DN * PN * AN;
  localparam int unsigned RW    = NP * PN;
  localparam int unsigned PIX_W = 1;
  localparam int unsigned ACQ_W = 2;

  logic              clk;
  logic              res;
  logic              start;
  logic              in_valid;
  logic [NP-1:0]     in_data;
  logic              in_ready;
  logic              hb_wr_en;
  logic [NP-1:0]     hb_data;
  logic              hb_pass;
  logic              hb_clr_n;
  logic [RW-1:0]     hb_result;
  logic [RW-1:0]     frame_result;
  logic              frame_done;
  logic              busy;
  logic [PIX_W-1:0]  pixel_idx;
  logic [ACQ_W-1:0]  acq_idx;

  sifh_frame_sequencer #(
    .NP(NP), .DATA_NUM(DN), .PIXEL_NUM(PN), .ACQ_NUM(AN), .PIPE_LAT(PL), .CLR_CYC(CC)
  ) dut (
    .clk(clk), .res(res), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .hb_wr_en(hb_wr_en), .hb_data(hb_data), .hb_pass(hb_pass),
    .hb_clr_n(hb_clr_n), .hb_result(hb_result), .frame_result(frame_result),
    .frame_done(frame_done), .busy(busy), .pixel_idx(pixel_idx), .acq_idx(acq_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait budget expired (t=%0t)", nm, $time);
  endtask

  // Behavioural model: phase 0 idle, 1 accepting, 2 post-pass gap, 3 capture.
  // Everything else is derived from the beat count of the frame and the gap cycle.
  int unsigned   m_phase = 0;
  int unsigned   m_beats = 0;
  int unsigned   m_gap   = 0;
  int unsigned   m_ff    = 0;
  logic          m_wr    = 1'b0;
  logic [NP-1:0] m_data  = '0;
  logic [RW-1:0] m_fr    = '0;
  logic          m_done  = 1'b0;

  initial forever begin
    @(posedge clk or negedge res);
    if (!res) begin
      m_phase = 0; m_beats = 0; m_gap = 0;
      m_wr = 1'b0; m_data = '0; m_fr = '0; m_done = 1'b0;
    end else begin
      m_wr   = 1'b0;
      m_done = 1'b0;
      case (m_phase)
        0: if (start) m_phase = 1;
        1: if (in_valid) begin
             m_beats++;
             m_wr   = 1'b1;
             m_data = in_data;
             if (in_data == '1) m_ff++;
             if (m_beats % B == 0) begin m_phase = 2; m_gap = 0; end
           end
        2: begin
             m_gap++;
             if (m_gap == PL + CC) m_phase = (m_beats == B) ? 1 : 3;
           end
        default: begin
             m_fr    = hb_result;
             m_done  = 1'b1;
             m_beats = 0;
`ifdef SIFH_AUTO_RESTART_EN
             m_phase = 1;
`else
             m_phase = 0;
`endif
           end
      endcase
    end
  end

  // Per-frame statistics, restarted whenever the driver bumps stats_epoch
  int unsigned stats_epoch = 0;
  int unsigned seen_epoch  = 0;
  int unsigned done_total  = 0;
  int unsigned st_wr0, st_wr1, st_clr, st_busy, st_gap, st_ff, st_done, st_busy_low;
  bit          st_seen;

  // Compare process: every output against the model on every falling edge
  initial forever begin
    int unsigned r;
    @(negedge clk);
    if (chk_en) begin
      r = m_beats % B;
      chk("in_ready",     64'(in_ready),     64'(m_phase == 1));
      chk("hb_wr_en",     64'(hb_wr_en),     64'(m_wr));
      chk("hb_data",      64'(hb_data),      64'(m_data));
      chk("hb_pass",      64'(hb_pass),
          64'((m_phase != 0) && (m_beats > B || (m_beats == B && m_phase == 1))));
      chk("hb_clr_n",     64'(hb_clr_n),     64'(!(m_phase == 2 && m_gap >= PL)));
      chk("busy",         64'(busy),         64'(m_phase != 0));
      chk("frame_done",   64'(frame_done),   64'(m_done));
      chk("frame_result", 64'(frame_result), 64'(m_fr));
      chk("pixel_idx",    64'(pixel_idx),    64'((r / DN) % PN));
      chk("acq_idx",      64'(acq_idx),      64'(r / (DN * PN)));
    end
    if (stats_epoch != seen_epoch) begin
      seen_epoch = stats_epoch;
      st_wr0 = 0; st_wr1 = 0; st_clr = 0; st_busy = 0; st_gap = 0;
      st_ff = 0; st_done = 0; st_busy_low = 0; st_seen = 1'b0;
    end
    if (frame_done === 1'b1) begin
      done_total++;
      if (!st_seen) begin st_done++; st_seen = 1'b1; end
    end else if (!st_seen) begin
      if (hb_wr_en === 1'b1 && hb_pass === 1'b0) st_wr0++;
      if (hb_wr_en === 1'b1 && hb_pass === 1'b1) st_wr1++;
      if (hb_wr_en === 1'b1 && hb_data === '1)   st_ff++;
      if (hb_clr_n === 1'b0) st_clr++;
      if (busy === 1'b1) st_busy++;
      if (busy === 1'b1 && in_ready === 1'b0 && hb_clr_n === 1'b1) st_gap++;
    end
    if (busy !== 1'b1) st_busy_low++;
  end

  logic [NP-1:0] data_ctr = '0;
  int unsigned   cyc_ctr  = 0;

  // Drive one cycle of stream stimulus; returns #1 after the next rising edge
  task automatic drive_cycle(input bit rnd, input bit inj);
    in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (inj && (cyc_ctr % 5 == 2)) begin
      in_data = '1;
    end else begin
      in_data  = data_ctr;
      data_ctr = data_ctr + NP'(1);
    end
    cyc_ctr++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit rnd, input bit inj, input int unsigned budget, input string nm);
    int unsigned n = 0;
    while (!st_seen && n < budget) begin drive_cycle(rnd, inj); n++; end
    if (!st_seen) fail_now(nm);
  endtask

  task automatic run_frame(input bit rnd, input bit inj, input int unsigned budget, input string nm);
    stats_epoch++;
    start = 1'b1;
    drive_cycle(rnd, inj);
    start = 1'b0;
    wait_done(rnd, inj, budget, nm);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_in_ready"},     64'(in_ready),     64'd0);
    chk({nm, "_hb_wr_en"},     64'(hb_wr_en),     64'd0);
    chk({nm, "_hb_data"},      64'(hb_data),      64'd0);
    chk({nm, "_hb_pass"},      64'(hb_pass),      64'd0);
    chk({nm, "_hb_clr_n"},     64'(hb_clr_n),     64'd1);
    chk({nm, "_frame_result"}, 64'(frame_result), 64'd0);
    chk({nm, "_frame_done"},   64'(frame_done),   64'd0);
    chk({nm, "_busy"},         64'(busy),         64'd0);
    chk({nm, "_pixel_idx"},    64'(pixel_idx),    64'd0);
    chk({nm, "_acq_idx"},      64'(acq_idx),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned n;
    int unsigned ff_base;
    res = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; hb_result = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    chk_en = 1'b1;
    res    = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: continuous stream, full frame with literal timing counts
    hb_result = 20'hABCDE;
    run_frame(1'b0, 1'b0, 200, "t1_frame");
    chk("t1_wr_coarse", 64'(st_wr0),       64'd12);
    chk("t1_wr_fine",   64'(st_wr1),       64'd12);
    chk("t1_clr_low",   64'(st_clr),       64'd4);
    chk("t1_busy_cyc",  64'(st_busy),      64'd35);
    chk("t1_gap_cyc",   64'(st_gap),       64'd7);
    chk("t1_result",    64'(frame_result), 64'h0ABCDE);

`ifdef SIFH_AUTO_RESTART_EN
    // Test 6: frames keep coming without further start pulses
    stats_epoch++;
    hb_result = 20'h55AA5;
    base = done_total;
    n    = 0;
    while (done_total < base + 3 && n < 300) begin drive_cycle(1'b0, 1'b0); n++; end
    if (done_total < base + 3) fail_now("t6_frames");
    chk("t6_busy_low", 64'(st_busy_low),  64'd0);
    chk("t6_result",   64'(frame_result), 64'h055AA5);
`else
    // Test 2: randomly stalled stream
    hb_result = 20'h13579;
    run_frame(1'b1, 1'b0, 400, "t2_frame");
    chk("t2_wr_coarse", 64'(st_wr0),       64'd12);
    chk("t2_wr_fine",   64'(st_wr1),       64'd12);
    chk("t2_clr_low",   64'(st_clr),       64'd4);
    chk("t2_result",    64'(frame_result), 64'h013579);

    // Test 3: no-photon sentinels mixed into the stream
    hb_result = 20'h2468A;
    ff_base   = m_ff;
    run_frame(1'b1, 1'b1, 400, "t3_frame");
    chk("t3_ff_fwd",    64'(st_ff),        64'(m_ff - ff_base));
    chk("t3_wr_coarse", 64'(st_wr0),       64'd12);
    chk("t3_wr_fine",   64'(st_wr1),       64'd12);
    chk("t3_result",    64'(frame_result), 64'h02468A);

    // Test 4: reset in the middle of the fine pass
    stats_epoch++;
    hb_result = 20'hFFFFF;
    start = 1'b1;
    drive_cycle(1'b0, 1'b0);
    start = 1'b0;
    n = 0;
    while (m_beats != B + 7 && n < 200) begin drive_cycle(1'b0, 1'b0); n++; end
    if (m_beats != B + 7) fail_now("t4_reach_fine");
    chk("t4_fine_pass", 64'(hb_pass), 64'd1);
    res = 1'b0;
    #1;
    check_reset_vals("t4_abort");
    repeat (3) drive_cycle(1'b0, 1'b0);
    chk("t4_no_done", 64'(st_done), 64'd0);
    res = 1'b1;
    repeat (2) drive_cycle(1'b0, 1'b0);
    hb_result = 20'h0F0F0;
    run_frame(1'b0, 1'b0, 200, "t4_frame");
    chk("t4_wr_coarse", 64'(st_wr0),       64'd12);
    chk("t4_wr_fine",   64'(st_wr1),       64'd12);
    chk("t4_busy_cyc",  64'(st_busy),      64'd35);
    chk("t4_result",    64'(frame_result), 64'h00F0F0);

    // Test 5: start pulses during COARSE and CAPTURE are ignored
    stats_epoch++;
    hb_result = 20'h3C3C3;
    start = 1'b1;
    drive_cycle(1'b0, 1'b0);
    start = 1'b0;
    repeat (4) drive_cycle(1'b0, 1'b0);
    start = 1'b1;
    drive_cycle(1'b0, 1'b0);
    start = 1'b0;
    n = 0;
    while (m_phase != 3 && n < 200) begin drive_cycle(1'b0, 1'b0); n++; end
    if (m_phase != 3) fail_now("t5_reach_capture");
    start = 1'b1;
    drive_cycle(1'b0, 1'b0);
    start = 1'b0;
    wait_done(1'b0, 1'b0, 50, "t5_frame");
    repeat (3) drive_cycle(1'b0, 1'b0);
    chk("t5_idle",      64'(busy),         64'd0);
    chk("t5_wr_coarse", 64'(st_wr0),       64'd12);
    chk("t5_wr_fine",   64'(st_wr1),       64'd12);
    chk("t5_busy_cyc",  64'(st_busy),      64'd35);
    chk("t5_result",    64'(frame_result), 64'h03C3C3);
`endif

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
